// File: rtl/cp0_irq_if.sv
// ============================================================================
// cp0_irq_if : CPU-side bus of the CP0 exception/interrupt controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface cp0_irq_if #(
  parameter int unsigned NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq;
  logic               ov;
  logic [31:0]        pc;
  logic [4:0]         rd;
  logic               mtc0_we;
  logic [31:0]        wdata;
  logic               eret;
  logic [31:0]        rdata;
  logic               exc_take;
  logic [31:0]        exc_vec;
  logic               exc_ret;
  logic [31:0]        epc_out;
  logic [NUM_IRQ-1:0] inta;

  modport master (
    output irq, ov, pc, rd, mtc0_we, wdata, eret,
    input  rdata, exc_take, exc_vec, exc_ret, epc_out, inta
  );

  modport slave (
    input  irq, ov, pc, rd, mtc0_we, wdata, eret,
    output rdata, exc_take, exc_vec, exc_ret, epc_out, inta
  );
endinterface

`default_nettype wire

// File: rtl/cp0_irq_controller.sv
// ============================================================================
// cp0_irq_controller : CP0 Status/Cause/EPC with prioritised exception entry
// Rev 1.0
// ============================================================================
`default_nettype none

module cp0_irq_controller #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter bit          IRQ_EDGE   = 1'b1,
  parameter logic [31:0] IBASE      = 32'h54,
  parameter int unsigned VEC_STRIDE = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  cp0_irq_if.slave   bus
);
  localparam logic [0:0]  ST_RUN     = 1'b0;
  localparam logic [0:0]  ST_HANDLER = 1'b1;
  localparam logic [4:0]  REG_STATUS = 5'd28;
  localparam logic [4:0]  REG_CAUSE  = 5'd29;
  localparam logic [4:0]  REG_EPC    = 5'd30;
  localparam logic [4:0]  EXC_INT    = 5'd0;
  localparam logic [4:0]  EXC_OV     = 5'd12;
  localparam logic [31:0] STRIDE_W   = 32'(VEC_STRIDE);

  logic [0:0]         state_q, state_d;
  logic               ie_q, ie_d;
  logic [NUM_IRQ-1:0] im_q, im_d;
  logic [NUM_IRQ-1:0] ip_q, ip_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [4:0]         code_q, code_d;
  logic [31:0]        epc_q, epc_d;

  logic [NUM_IRQ-1:0] enabled;
  logic [NUM_IRQ-1:0] grant;
  logic [3:0]         vec_idx;
  logic               take, int_take;
  logic               wr_status, wr_cause, wr_epc;

  assign enabled   = ip_q & im_q;
  assign take      = (state_q == ST_RUN) && ie_q && (bus.ov || (|enabled));
  assign int_take  = take && !bus.ov;
  // A take squashes the instruction, so its mtc0 is dropped
  assign wr_status = bus.mtc0_we && !take && (bus.rd == REG_STATUS);
  assign wr_cause  = bus.mtc0_we && !take && (bus.rd == REG_CAUSE);
  assign wr_epc    = bus.mtc0_we && !take && (bus.rd == REG_EPC);

  // Scan from the top so the lowest enabled line is the last one to win
  always_comb begin
    grant   = '0;
    vec_idx = 4'd0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (enabled[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        vec_idx  = 4'(i + 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (take)                                     state_d = ST_HANDLER;
    else if (wr_status)                           state_d = bus.wdata[1];
    else if (bus.eret && state_q == ST_HANDLER)   state_d = ST_RUN;
  end

  always_comb begin
    bus.exc_take = take;
    bus.exc_vec  = IBASE + STRIDE_W * (bus.ov ? 32'd0 : {28'd0, vec_idx});
    bus.inta     = int_take ? grant : '0;
    bus.exc_ret  = bus.eret && !take;
    bus.epc_out  = epc_q;
    bus.rdata    = '0;
    case (bus.rd)
      REG_STATUS: begin
        bus.rdata[0]            = ie_q;
        bus.rdata[1]            = state_q[0];
        bus.rdata[8 +: NUM_IRQ] = im_q;
      end
      REG_CAUSE: begin
        bus.rdata[6:2]          = code_q;
        bus.rdata[8 +: NUM_IRQ] = ip_q;
      end
      REG_EPC:  bus.rdata = epc_q;
      default:  bus.rdata = '0;
    endcase
  end

  always_comb begin
    ie_d   = ie_q;
    im_d   = im_q;
    code_d = code_q;
    epc_d  = epc_q;
    if (take) begin
      epc_d  = bus.pc;
      code_d = bus.ov ? EXC_OV : EXC_INT;
    end else begin
      if (wr_status) begin
        ie_d = bus.wdata[0];
        im_d = bus.wdata[8 +: NUM_IRQ];
      end
      if (wr_epc) epc_d = bus.wdata;
    end
  end

  generate
    if (IRQ_EDGE) begin : g_edge
      logic [NUM_IRQ-1:0] rise, clr;
      assign rise = bus.irq & ~irq_prev_q;
      assign clr  = (int_take ? grant : '0) | (wr_cause ? bus.wdata[8 +: NUM_IRQ] : '0);
      // A new edge outranks a clear on the same cycle
      assign ip_d = (ip_q & ~clr) | rise;
    end else begin : g_level
      assign ip_d = bus.irq;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ie_q       <= 1'b0;
      im_q       <= '0;
      ip_q       <= '0;
      irq_prev_q <= '0;
      code_q     <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      ie_q       <= ie_d;
      im_q       <= im_d;
      ip_q       <= ip_d;
      irq_prev_q <= bus.irq;
      code_q     <= code_d;
      epc_q      <= epc_d;
    end
  end
endmodule

`default_nettype wire
